// File: rtl/mips_mem_pkg.sv
// Shared types for the unified-memory port arbiter and related memory-side FSMs.
//   arb_state_t : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   owner_t     : which pipeline port owns the access in flight
//   BE_W        : byte-enable width for the default 32-bit data path
package mips_mem_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned BE_W       = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts enabled cycles and flags the cycle in which the TIMEOUT-th enabled cycle occurs.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : count this cycle (e.g. waiting for an ack)
//   clr_i      : synchronous clear, dominates en_i
//   expired_o  : high during the TIMEOUT-th consecutive enabled cycle
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Combinational so the owning FSM can abort in the same cycle the limit is hit.
    assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (I) and load/store (D).
// Data has priority; after STARVE_MAX consecutive D grants with a fetch waiting, the
// fetch is forced through. An access that sees no mem_ack for TIMEOUT cycles is aborted
// with err and zeroed read data.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   i_req/i_addr -> i_rdata/i_done  : fetch port, i_stall to PC/IF_ID
//   d_req/d_we/d_be/d_addr/d_wdata  : data port, d_rdata/d_done, d_stall to pipeline
//   err                             : pulses with done when an access timed out
//   mem_req/we/be/addr/wdata        : external request, held until mem_ack
//   mem_ack/mem_rdata               : external completion, read data valid with ack
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_done,
    output logic                i_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_stall,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BeW = DATA_W / 8;
    localparam int unsigned StW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [BeW-1:0]    mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;
    logic              err_q, err_d;
    logic [StW-1:0]    starve_cnt_q, starve_cnt_d;

    logic              to_en;
    logic              to_clr;
    logic              to_expired;

    // Only cycles actually waiting on the memory count towards the timeout.
    assign to_en  = (state_q == BUSY) && !mem_ack;
    assign to_clr = (state_q == RESP);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (to_en),
        .clr_i     (to_clr),
        .expired_o (to_expired)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_cnt_d = starve_cnt_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        err_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!i_req) begin
                    starve_cnt_d = '0;
                end
                if (d_req && !(i_req && (starve_cnt_q == StW'(STARVE_MAX)))) begin
                    state_d     = BUSY;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (i_req && (starve_cnt_q != StW'(STARVE_MAX))) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (i_req) begin
                    state_d      = BUSY;
                    owner_d      = OWN_I;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_be_d     = '1;
                    mem_addr_d   = i_addr;
                    mem_wdata_d  = '0;
                    starve_cnt_d = '0;
                end
            end
            BUSY: begin
                if (mem_ack || to_expired) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = !mem_ack;
                    if (owner_q == OWN_I) begin
                        i_done_d  = 1'b1;
                        i_rdata_d = mem_ack ? mem_rdata : '0;
                    end else begin
                        d_done_d = 1'b1;
                        // Stores leave the load-data register untouched.
                        if (!mem_we_q) begin
                            d_rdata_d = mem_ack ? mem_rdata : '0;
                        end
                    end
                end
            end
            RESP: begin
                // No arbitration here: a request still high is the one just finished.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            err_q        <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            err_q        <= err_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    assign err       = err_q;

    assign i_stall = i_req & ~i_done_q;
    assign d_stall = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected memory requests and
// port responses into queues; a negedge monitor pops and compares them as they appear.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done, i_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done, d_stall, err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } mreq_t;

    resp_t exp_resp[$];
    mreq_t exp_mem[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_cnt = 0;
    int          last_len = 0;
    int          ack_delay = 1;
    bit          never_ack = 1'b0;
    int          d_keep = 1;
    bit          req_prev = 1'b0;
    mreq_t       cur_mem;
    logic [31:0] model_d = '0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2008_0005;
            32'h0000_0100: return 32'h8C08_0100;
            default:       return {~a[15:0], a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks in the ack_delay-th cycle of mem_req unless never_ack.
    always @(negedge clk) begin
        if (mem_req) begin
            busy_cnt++;
            last_len = busy_cnt;
            mem_ack  = !never_ack && (busy_cnt == ack_delay);
            mem_rdata = mem_ack ? mem_fn(mem_addr) : 32'h0;
        end else begin
            busy_cnt = 0;
            mem_ack  = 1'b0;
        end
    end

    // Monitor: compares requests and completions, then drops finished requests.
    always @(negedge clk) begin
        if (!rst_n) begin
            req_prev = 1'b0;
        end else begin
            if (mem_req && !req_prev) begin
                if (exp_mem.size() == 0) begin
                    chk("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    cur_mem = exp_mem.pop_front();
                    chk("mem_addr", mem_addr, cur_mem.addr);
                    chk("mem_we", 32'(mem_we), 32'(cur_mem.we));
                    chk("mem_be", 32'(mem_be), 32'(cur_mem.be));
                    if (cur_mem.we) chk("mem_wdata", mem_wdata, cur_mem.wdata);
                    if (cur_mem.cyc >= 0) chk("mem_req_cycle", 32'(cyc), 32'(cur_mem.cyc));
                end
            end else if (mem_req) begin
                chk("mem_addr_stable", mem_addr, cur_mem.addr);
            end
            req_prev = mem_req;

            if (i_done && d_done) chk("both_done", 32'(i_done & d_done), 32'h0);
            if (i_done || d_done) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_done", 32'({i_done, d_done}), 32'h0);
                end else begin
                    resp_t e;
                    e = exp_resp.pop_front();
                    chk("owner_is_d", 32'(d_done), 32'(e.is_d));
                    chk("rdata", d_done ? d_rdata : i_rdata, e.rdata);
                    chk("err", 32'(err), 32'(e.err));
                    if (e.cyc >= 0) chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
                if (i_done) begin
                    chk("i_stall_at_done", 32'(i_stall), 32'h0);
                    i_req = 1'b0;
                end
                if (d_done) begin
                    chk("d_stall_at_done", 32'(d_stall), 32'h0);
                    d_keep--;
                    if (d_keep <= 0) d_req = 1'b0;
                end
            end
        end
    end

    task automatic push_d(input logic [31:0] a, input bit we, input logic [3:0] be,
                          input logic [31:0] wd, input int mcyc, input int rcyc);
        exp_mem.push_back('{addr: a, we: we, be: be, wdata: wd, cyc: mcyc});
        if (!we) model_d = mem_fn(a);
        exp_resp.push_back('{is_d: 1'b1, rdata: model_d, err: 1'b0, cyc: rcyc});
    endtask

    task automatic push_i(input logic [31:0] a, input int mcyc, input int rcyc);
        exp_mem.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0, cyc: mcyc});
        exp_resp.push_back('{is_d: 1'b0, rdata: mem_fn(a), err: 1'b0, cyc: rcyc});
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while (n < budget && (exp_resp.size() != 0 || exp_mem.size() != 0 || mem_req)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_resp", 32'(exp_resp.size()), 32'h0);
    endtask

    int c0;

    initial begin
        #12;
        chk("rst_ctrl", 32'({mem_req, mem_we, mem_be, i_done, d_done, err, i_stall, d_stall}),
            32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", i_rdata | d_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lone fetch, ack in the second mem_req cycle.
        @(negedge clk);
        ack_delay = 2;
        c0 = cyc;
        i_addr = 32'h40;
        i_req  = 1'b1;
        push_i(32'h40, c0 + 1, c0 + 3);
        #1 chk("i_stall_c0", 32'(i_stall), 32'h1);
        @(negedge clk);
        chk("i_stall_c1", 32'(i_stall), 32'h1);
        @(negedge clk);
        chk("i_stall_c2", 32'(i_stall), 32'h1);
        wait_quiet(20);
        chk("fetch_req_len", 32'(last_len), 32'd2);

        // Collision: data first, then fetch.
        @(negedge clk);
        ack_delay = 1;
        c0 = cyc;
        d_addr = 32'h100; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
        i_addr = 32'h44;
        d_keep = 1;
        d_req = 1'b1;
        i_req = 1'b1;
        push_d(32'h100, 1'b0, 4'hF, 32'h0, c0 + 1, c0 + 2);
        push_i(32'h44, c0 + 4, c0 + 5);
        #1 chk("stalls_c0", 32'({i_stall, d_stall}), 32'h3);
        wait_quiet(30);

        // Starvation guard: 4 D grants, forced I grant, then D resumes.
        @(negedge clk);
        d_addr = 32'h400;
        i_addr = 32'h80;
        d_keep = 5;
        d_req = 1'b1;
        i_req = 1'b1;
        for (int k = 0; k < 4; k++) push_d(32'h400, 1'b0, 4'hF, 32'h0, -1, -1);
        push_i(32'h80, -1, -1);
        push_d(32'h400, 1'b0, 4'hF, 32'h0, -1, -1);
        wait_quiet(100);
        chk("starve_cnt_zero", 32'(dut.starve_cnt_q), 32'h0);

        // Byte store: load-data register must not change.
        @(negedge clk);
        c0 = cyc;
        d_we = 1'b1; d_be = 4'b0100; d_addr = 32'h204; d_wdata = 32'h00AB_0000;
        d_keep = 1;
        d_req = 1'b1;
        push_d(32'h204, 1'b1, 4'b0100, 32'h00AB_0000, c0 + 1, c0 + 2);
        wait_quiet(20);
        d_we = 1'b0; d_be = 4'hF;

        // Timeout: no ack, abort after 8 mem_req cycles with err and zeroed data.
        @(negedge clk);
        never_ack = 1'b1;
        c0 = cyc;
        d_addr = 32'h300;
        d_keep = 1;
        d_req = 1'b1;
        exp_mem.push_back('{addr: 32'h300, we: 1'b0, be: 4'hF, wdata: 32'h0, cyc: c0 + 1});
        model_d = 32'h0;
        exp_resp.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1, cyc: c0 + 9});
        wait_quiet(40);
        chk("timeout_req_len", 32'(last_len), 32'd8);
        chk("fsm_idle", 32'(dut.state_q), 32'(IDLE));

        // Reset mid-access: mem_req drops without a clock edge, then re-grant.
        @(negedge clk);
        d_addr = 32'h500;
        d_keep = 1;
        d_req = 1'b1;
        push_d(32'h500, 1'b0, 4'hF, 32'h0, -1, -1);
        repeat (3) @(negedge clk);
        chk("busy_before_rst", 32'(mem_req), 32'h1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("mem_req_async_rst", 32'(mem_req), 32'h0);
        chk("rst_outputs", 32'({i_done, d_done, err}), 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        exp_resp.delete();
        exp_mem.delete();
        @(negedge clk);
        never_ack = 1'b0;
        ack_delay = 1;
        rst_n = 1'b1;
        c0 = cyc;
        push_d(32'h500, 1'b0, 4'hF, 32'h0, c0 + 1, c0 + 2);
        @(posedge clk);
        #1 chk("regrant_first_edge", 32'(mem_req), 32'h1);
        wait_quiet(20);

        chk("mem_queue_empty", 32'(exp_mem.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch and the MEM-stage load/store.
- Replaces the separate instruction and data memories.
- Serialises accesses, drives the external memory handshake and generates per-port stall/done signals for the pipeline.
- Data port has priority, with a starvation guard for fetch and a timeout for a non-responding memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
TIMEOUT, 255, max cycles mem_req may wait for mem_ack before abort

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request, held until i_done
i_addr  in  ADDR_W  fetch address (PC)
i_rdata  out  DATA_W  fetched instruction, valid when i_done
i_done  out  1  one-cycle fetch completion pulse
i_stall  out  1  fetch stall to PC/IF_ID
d_req  in  1  data request, held until d_done
d_we  in  1  1=store, 0=load
d_be  in  DATA_W/8  byte enables (storeByte → one lane)
d_addr  in  ADDR_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_done
d_done  out  1  one-cycle data completion pulse
d_stall  out  1  whole-pipeline stall
err  out  1  one-cycle pulse with done on timeout
mem_req  out  1  external request, held until mem_ack
mem_we  out  1  write strobe
mem_be  out  DATA_W/8  byte enables
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory completion; mem_rdata valid same cycle
mem_rdata  in  DATA_W  read data

Behaviour:
- Reset (async, immediate): state IDLE.
  - All outputs 0; mem_* registers 0; starve_cnt 0; timeout_cnt 0.
  - A reset mid-access drops mem_req at once; the access is lost and the requester reissues it.
- States: IDLE → BUSY → RESP → IDLE.
- IDLE, arbitration:
  - if d_req and not (i_req and starve_cnt==STARVE_MAX): grant D;
  - else if i_req: grant I;
  - else stay in IDLE.
  - On grant, register addr/we/be/wdata and the grant owner; mem_req=1 from the next cycle (BUSY).
  - A fetch grant forces mem_we=0 and mem_be all ones.
- starve_cnt:
  - +1 on each D grant while i_req=1, saturating at STARVE_MAX;
  - cleared on any I grant, or in IDLE when i_req=0.
- BUSY:
  - mem_* held stable.
  - On mem_ack: capture mem_rdata into the owner's rdata register, clear mem_req, go to RESP.
  - timeout_cnt increments each BUSY cycle without ack. When it reaches TIMEOUT: clear mem_req, rdata=0, set err, go to RESP.
- RESP:
  - Owner's done=1 for exactly one cycle (err with it if timed out); timeout_cnt cleared; next state IDLE.
  - No arbitration occurs in RESP, so a request still high in RESP is not double-issued.
  - A requester presents its next request from the cycle after done.
- Latency: grant in cycle 0 (IDLE); mem_ack at cycle k≥1; done at k+1; next grant at k+2. Minimum 3 cycles per access.
- Stalls (combinational):
  - i_stall = i_req & ~i_done.
  - d_stall = d_req & ~d_done.
- Stores: d_rdata is not updated; d_done still pulses.
- mem_ack outside BUSY is ignored.
- Input changes while BUSY are ignored because the request is registered.
- i_rdata/d_rdata hold their last value until overwritten.

Decomposition:
- Package mips_mem_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP};
  - owner_t enum {OWN_I, OWN_D};
  - BE_W = DATA_W/8.
- One natural sub-module, arb_timeout_counter: enable/clear inputs, TIMEOUT parameter, expired output. It is reused later by the cache fill FSM.

Test Plan:
- Lone fetch:
  - Stimulus: i_req=1, i_addr=0x0000_0040; memory acks 2 cycles after mem_req with 0x2008_0005.
  - Response: mem_req cycles 1-2, mem_addr=0x40, mem_we=0; i_done at cycle 3 with i_rdata=0x2008_0005; i_stall high cycles 0-2.
- Collision:
  - Stimulus: i_req and d_req (load 0x100) raised the same cycle; single-cycle ack.
  - Response: data is served first (d_done cycle 2), then fetch (grant cycle 3, i_done cycle 5).
- Starvation:
  - Stimulus: d_req held continuously with i_req=1, STARVE_MAX=4.
  - Response: exactly 4 D grants, then 1 I grant, then D resumes; starve_cnt returns to 0.
- Store byte:
  - Stimulus: d_we=1, d_be=4'b0100, d_addr=0x204, d_wdata=0x00AB_0000.
  - Response: mem_we=1, mem_be=0100, mem_wdata=0x00AB_0000; d_done pulses; d_rdata unchanged.
- Timeout:
  - Stimulus: mem_ack never asserted, TIMEOUT=8.
  - Response: mem_req high 8 cycles then drops; d_done and err pulse together with d_rdata=0; FSM back to IDLE.
- Reset mid-access:
  - Stimulus: rst_n low during BUSY.
  - Response: mem_req=0 immediately without a clock edge; after release, FSM in IDLE and a held request is re-granted on the first edge.
